// File: rtl/alu_issue_stage_if.sv
// Handshake/bus bundle for the ALU issue stage: decoded-instruction input side and
// registered ALU-operand output side. slave = the stage, master = its environment.
interface alu_issue_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_insn;
  logic [WIDTH-1:0] in_rs_data;
  logic [WIDTH-1:0] in_rt_data;

  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_alu_op;
  logic [4:0]       out_shamt;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [4:0]       out_rd;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_insn, in_rs_data, in_rt_data, out_ready,
    output in_ready, out_valid, out_alu_op, out_shamt, out_a, out_b, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_insn, in_rs_data, in_rt_data, out_ready,
    input  in_ready, out_valid, out_alu_op, out_shamt, out_a, out_b, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: decodes the instruction on capture into a main/skid register pair.
// Optional macro ALU_ISSUE_STALL_CNT_EN adds a saturating output-stall counter (stall_cnt).
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 17
) (
  input  logic              clock,
  input  logic              resetn,
`ifdef ALU_ISSUE_STALL_CNT_EN
  alu_issue_stage_if.slave  bus,
  output logic [31:0]       stall_cnt
`else
  alu_issue_stage_if.slave  bus
`endif
);

  typedef struct packed {
    logic [4:0]       alu_op;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       rd;
    logic             illegal;
  } entry_t;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] OPC_ADDI  = 5'b00101;
  localparam logic [4:0] ALU_ADD   = 5'b00000;

  function automatic logic signed [WIDTH-1:0] sext_imm(input logic signed [IMM_W-1:0] imm);
    return {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  entry_t dec;
  entry_t main_q;
  entry_t skid_q;
  logic   main_vld;
  logic   skid_vld;
  logic   accept;
  logic   consume;
  logic   unused_rs_field;

  // rs index is resolved upstream; only its data arrives here
  assign unused_rs_field = ^bus.in_insn[21:17];

  always_comb begin
    dec.alu_op  = ALU_ADD;
    dec.shamt   = 5'd0;
    dec.a       = bus.in_rs_data;
    dec.b       = bus.in_rt_data;
    dec.rd      = bus.in_insn[26:22];
    dec.illegal = 1'b0;
    case (bus.in_insn[31:27])
      OPC_RTYPE: begin
        dec.alu_op = bus.in_insn[6:2];
        dec.shamt  = bus.in_insn[11:7];
      end
      OPC_ADDI: dec.b = sext_imm(bus.in_insn[IMM_W-1:0]);
      default:  dec.illegal = 1'b1;
    endcase
  end

  // in_ready is simply the inverted skid flag, so it is registered by construction
  assign accept  = bus.in_valid && !skid_vld;
  assign consume = main_vld && bus.out_ready;

  // Stage boundary: main register drives the ALU, skid absorbs the one in-flight entry
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (consume && skid_vld) begin
      main_q   <= skid_q;
      skid_vld <= 1'b0;
    end else if (accept && (!main_vld || consume)) begin
      main_q   <= dec;
      main_vld <= 1'b1;
    end else if (accept) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end else if (consume) begin
      main_vld <= 1'b0;
    end
  end

  assign bus.in_ready    = !skid_vld;
  assign bus.out_valid   = main_vld;
  assign bus.out_alu_op  = main_q.alu_op;
  assign bus.out_shamt   = main_q.shamt;
  assign bus.out_a       = main_q.a;
  assign bus.out_b       = main_q.b;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_illegal = main_q.illegal;

`ifdef ALU_ISSUE_STALL_CNT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= 32'd0;
    end else if (main_vld && !bus.out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, hand-written backpressure/reset
// sequences and a randomized run against a FIFO-level reference model.
module tb_alu_issue_stage;
  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  alu_issue_stage_if #(.WIDTH(WIDTH)) bi ();

`ifdef ALU_ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
  alu_issue_stage #(.WIDTH(WIDTH), .IMM_W(17)) dut (
    .clock(clock), .resetn(resetn), .bus(bi), .stall_cnt(stall_cnt));
`else
  alu_issue_stage #(.WIDTH(WIDTH), .IMM_W(17)) dut (
    .clock(clock), .resetn(resetn), .bus(bi));
`endif

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } out_t;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs;
    logic [31:0] rt;
    out_t        exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vt[7];
  out_t q[$];
  int unsigned model_stall;

  function automatic out_t mk(input int op, input int sh, input logic [31:0] a,
                              input logic [31:0] b, input int rd, input bit ill);
    out_t r;
    r.op = 5'(op); r.sh = 5'(sh); r.a = a; r.b = b; r.rd = 5'(rd); r.ill = ill;
    return r;
  endfunction

  function automatic out_t actual();
    return {bi.out_alu_op, bi.out_shamt, bi.out_a, bi.out_b, bi.out_rd, bi.out_illegal};
  endfunction

  // Reference decode written from the field definitions with plain arithmetic
  function automatic out_t ref_decode(input logic [31:0] insn, input logic [31:0] rs,
                                      input logic [31:0] rt);
    int unsigned opc = insn / (1 << 27);
    int imm;
    if (opc == 0)
      return mk(int'((insn / 4) % 32), int'((insn / 128) % 32), rs, rt,
                int'((insn / (1 << 22)) % 32), 1'b0);
    if (opc == 5) begin
      imm = int'(insn % 32'h20000);
      if (imm >= 'h10000) imm = imm - 'h20000;
      return mk(0, 0, rs, 32'(imm), int'((insn / (1 << 22)) % 32), 1'b0);
    end
    return mk(0, 0, rs, rt, int'((insn / (1 << 22)) % 32), 1'b1);
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input vec_t x);
    bi.in_valid   = v;
    bi.in_insn    = x.insn;
    bi.in_rs_data = x.rs;
    bi.in_rt_data = x.rt;
  endtask

  task automatic idle();
    bi.in_valid   = 1'b0;
    bi.in_insn    = 32'd0;
    bi.in_rs_data = 32'd0;
    bi.in_rt_data = 32'd0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    bi.out_ready = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    vt[0] = '{32'h00A21100, 32'd5, 32'd7, mk(0, 2, 32'd5, 32'd7, 2, 1'b0)};
    vt[1] = '{32'h00C80F94, 32'h80000000, 32'h12345678,
              mk(5, 31, 32'h80000000, 32'h12345678, 3, 1'b0)};
    vt[2] = '{32'h2841FFFF, 32'd0, 32'hDEADBEEF, mk(0, 0, 32'd0, 32'hFFFFFFFF, 1, 1'b0)};
    vt[3] = '{32'h29C00123, 32'd10, 32'd99, mk(0, 0, 32'd10, 32'h00000123, 7, 1'b0)};
    vt[4] = '{32'hFFC00F8C, 32'h11, 32'h22, mk(0, 0, 32'h11, 32'h22, 31, 1'b1)};
    vt[5] = '{32'h0240007C, 32'd1, 32'd2, mk(31, 0, 32'd1, 32'd2, 9, 1'b0)};
    vt[6] = '{32'h01000688, 32'hF0F0F0F0, 32'h0FF00FF0,
              mk(2, 13, 32'hF0F0F0F0, 32'h0FF00FF0, 4, 1'b0)};

    idle();
    bi.out_ready = 1'b0;
    resetn = 1'b0;
    repeat (2) tick();
    check("reset_out_valid", 80'(bi.out_valid), 80'(0));
    check("reset_in_ready", 80'(bi.in_ready), 80'(1));
    check("reset_fields", actual(), 80'(0));
    resetn = 1'b1;

    // Directed table, first vector lands on the first edge after reset release
    bi.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vt[i]);
      tick();
      check($sformatf("vec%0d_valid", i), 80'(bi.out_valid), 80'(1));
      check($sformatf("vec%0d_fields", i), actual(), vt[i].exp);
      idle();
      tick();
      check($sformatf("vec%0d_drained", i), 80'(bi.out_valid), 80'(0));
    end

    // Backpressure: three back-to-back with out_ready low
    bi.out_ready = 1'b0;
    drive(1'b1, vt[0]);
    tick();
    check("bp_ready_after_first", 80'(bi.in_ready), 80'(1));
    check("bp_first_out", actual(), vt[0].exp);
    drive(1'b1, vt[1]);
    tick();
    check("bp_ready_low", 80'(bi.in_ready), 80'(0));
    drive(1'b1, vt[2]);
    tick();
    check("bp_third_held", 80'(bi.in_ready), 80'(0));
    check("bp_out_stable", actual(), vt[0].exp);
    check("bp_valid_held", 80'(bi.out_valid), 80'(1));
    bi.out_ready = 1'b1;
    tick();
    check("bp_order1", actual(), vt[1].exp);
    check("bp_ready_back", 80'(bi.in_ready), 80'(1));
    tick();
    check("bp_order2", actual(), vt[2].exp);
    check("bp_order2_valid", 80'(bi.out_valid), 80'(1));
    idle();
    tick();
    check("bp_empty", 80'(bi.out_valid), 80'(0));

    // Asynchronous reset with both entries buffered
    bi.out_ready = 1'b0;
    drive(1'b1, vt[3]);
    tick();
    drive(1'b1, vt[4]);
    tick();
    idle();
    check("ar_full", 80'(bi.in_ready), 80'(0));
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("ar_out_valid", 80'(bi.out_valid), 80'(0));
    check("ar_in_ready", 80'(bi.in_ready), 80'(1));
    check("ar_fields", actual(), 80'(0));
    tick();
    resetn = 1'b1;
    tick();
    check("ar_no_ghost", 80'(bi.out_valid), 80'(0));

`ifdef ALU_ISSUE_STALL_CNT_EN
    check("stall_reset", 80'(stall_cnt), 80'(0));
    bi.out_ready = 1'b0;
    drive(1'b1, vt[0]);
    tick();
    idle();
    repeat (10) tick();
    check("stall_ten", 80'(stall_cnt), 80'(10));
    bi.out_ready = 1'b1;
    repeat (3) tick();
    check("stall_holds", 80'(stall_cnt), 80'(10));
`endif

    // Randomized run against the queue model
    do_reset();
    q.delete();
    model_stall = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit v;
      bit rdy;
      bit acc;
      bit con;
      logic [31:0] insn;
      vec_t x;
      int unsigned pick;
      v = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      pick = $urandom_range(0, 3);
      insn = $urandom;
      if (pick == 0 || pick == 3) insn[31:27] = 5'd0;
      else if (pick == 1) insn[31:27] = 5'd5;
      x.insn = insn;
      x.rs = $urandom;
      x.rt = $urandom;
      x.exp = '0;
      drive(v, x);
      bi.out_ready = rdy;
      @(negedge clock);
      check("rnd_out_valid", 80'(bi.out_valid), 80'(q.size() > 0));
      check("rnd_in_ready", 80'(bi.in_ready), 80'(q.size() < 2));
      if (q.size() > 0) check("rnd_fields", actual(), q[0]);
`ifdef ALU_ISSUE_STALL_CNT_EN
      check("rnd_stall", 80'(stall_cnt), 80'(model_stall));
`endif
      acc = v && (q.size() < 2);
      con = rdy && (q.size() > 0);
      if (q.size() > 0 && !rdy) model_stall++;
      if (con) void'(q.pop_front());
      if (acc) q.push_back(ref_decode(x.insn, x.rs, x.rt));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
